// File: rtl/pe_pkg.sv
// Shared helpers for the priority encoder family.
// idx_width sizes index buses so that consumers and the encoder always agree on width.
package pe_pkg;

    localparam int PE_MIN_N = 2;
    localparam int PE_MAX_N = 64;

    // Width of a binary index able to name n inputs, never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational n-input priority encoder: any-request flag and index of the highest set bit.
// No request yields index 0, so the index is only meaningful while z_c is high.
module priority_encoder_core
    import pe_pkg::*;
#(
    parameter int n = 6
) (
    input  logic [n-1:0]            w,
    output logic                    z_c,
    output logic [idx_width(n)-1:0] y_c
);

    localparam int YW = idx_width(n);

    generate
        if (n < PE_MIN_N || n > PE_MAX_N) begin : g_bad_n
            $error("priority_encoder_core: n must be in 2..64");
        end
    endgenerate

    // Ascending scan: the last set bit visited is the highest index, so it wins.
    always_comb begin
        z_c = |w;
        y_c = '0;
        for (int k = 0; k < n; k++) begin
            if (w[k]) begin
                y_c = YW'(k);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_generic.sv
// Registered priority encoder: samples w every cycle, presents z/y one cycle later.
// Synchronous active-high reset clears both outputs and drops any result in flight.
module priority_encoder_generic
    import pe_pkg::*;
#(
    parameter int n = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [n-1:0]            w,
    output logic                    z,
    output logic [idx_width(n)-1:0] y
);

    localparam int YW = idx_width(n);

    logic          z_c;
    logic [YW-1:0] y_c;

    logic          z_d, z_q;
    logic [YW-1:0] y_d, y_q;

    priority_encoder_core #(
        .n (n)
    ) u_core (
        .w   (w),
        .z_c (z_c),
        .y_c (y_c)
    );

    always_comb begin
        z_d = z_c;
        y_d = y_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            y_q <= '0;
        end else begin
            z_q <= z_d;
            y_q <= y_d;
        end
    end

    assign z = z_q;
    assign y = y_q;

endmodule

// File: tb/tb_priority_encoder_generic.sv
// Bench for priority_encoder_generic: directed table for n=6, reset sequences,
// and sweeps over n = 2, 5, 6, 8, 16 against a descending-scan reference model.
module tb_priority_encoder_generic;

    logic clk;
    logic rst;

    logic [5:0]  w6;
    logic        z6;
    logic [2:0]  y6;
    logic [1:0]  w2;
    logic        z2;
    logic [0:0]  y2;
    logic [4:0]  w5;
    logic        z5;
    logic [2:0]  y5;
    logic [7:0]  w8;
    logic        z8;
    logic [2:0]  y8;
    logic [15:0] w16;
    logic        z16;
    logic [3:0]  y16;

    int checks;
    int errors;

    typedef struct {
        logic [5:0] w;
        logic       z;
        logic [2:0] y;
    } vec_t;

    priority_encoder_generic #(.n(6))  dut6  (.clk(clk), .rst(rst), .w(w6),  .z(z6),  .y(y6));
    priority_encoder_generic #(.n(2))  dut2  (.clk(clk), .rst(rst), .w(w2),  .z(z2),  .y(y2));
    priority_encoder_generic #(.n(5))  dut5  (.clk(clk), .rst(rst), .w(w5),  .z(z5),  .y(y5));
    priority_encoder_generic #(.n(8))  dut8  (.clk(clk), .rst(rst), .w(w8),  .z(z8),  .y(y8));
    priority_encoder_generic #(.n(16)) dut16 (.clk(clk), .rst(rst), .w(w16), .z(z16), .y(y16));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan downward from the top bit and stop at the first one.
    function automatic int ref_idx(input logic [15:0] v, input int nn);
        for (int k = nn - 1; k >= 0; k--) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic ref_any(input logic [15:0] v, input int nn);
        for (int k = 0; k < nn; k++) begin
            if (v[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_all(input logic [15:0] v);
        w6  = v[5:0];
        w2  = v[1:0];
        w5  = v[4:0];
        w8  = v[7:0];
        w16 = v;
    endtask

    task automatic check_all(input logic [15:0] v);
        chk("n6_z",  16'(z6),  16'(ref_any(v, 6)));
        chk("n6_y",  16'(y6),  16'(ref_idx(v, 6)));
        chk("n2_z",  16'(z2),  16'(ref_any(v, 2)));
        chk("n2_y",  16'(y2),  16'(ref_idx(v, 2)));
        chk("n5_z",  16'(z5),  16'(ref_any(v, 5)));
        chk("n5_y",  16'(y5),  16'(ref_idx(v, 5)));
        chk("n8_z",  16'(z8),  16'(ref_any(v, 8)));
        chk("n8_y",  16'(y8),  16'(ref_idx(v, 8)));
        chk("n16_z", 16'(z16), 16'(ref_any(v, 16)));
        chk("n16_y", 16'(y16), 16'(ref_idx(v, 16)));
    endtask

    initial begin
        vec_t        tbl[12];
        logic [15:0] v;
        logic [15:0] prev;

        checks = 0;
        errors = 0;

        tbl[0]  = '{6'b000000, 1'b0, 3'd0};
        tbl[1]  = '{6'b000001, 1'b1, 3'd0};
        tbl[2]  = '{6'b000110, 1'b1, 3'd2};
        tbl[3]  = '{6'b101000, 1'b1, 3'd5};
        tbl[4]  = '{6'b000010, 1'b1, 3'd1};
        tbl[5]  = '{6'b000100, 1'b1, 3'd2};
        tbl[6]  = '{6'b001000, 1'b1, 3'd3};
        tbl[7]  = '{6'b010000, 1'b1, 3'd4};
        tbl[8]  = '{6'b100000, 1'b1, 3'd5};
        tbl[9]  = '{6'b011111, 1'b1, 3'd4};
        tbl[10] = '{6'b111111, 1'b1, 3'd5};
        tbl[11] = '{6'b000001, 1'b1, 3'd0};

        // Reset held two cycles with every request active.
        rst = 1'b1;
        drive_all(16'hFFFF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_z6",  16'(z6),  16'h0);
            chk("rst_y6",  16'(y6),  16'h0);
            chk("rst_z16", 16'(z16), 16'h0);
            chk("rst_y16", 16'(y16), 16'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_z6", 16'(z6), 16'h1);
        chk("post_rst_y6", 16'(y6), 16'h5);
        // All-ones boundary: y = n-1 for every width.
        chk("ones_y2",  16'(y2),  16'd1);
        chk("ones_y5",  16'(y5),  16'd4);
        chk("ones_y8",  16'(y8),  16'd7);
        chk("ones_y16", 16'(y16), 16'd15);

        // Directed table for n = 6, one vector per cycle.
        for (int i = 0; i < 12; i++) begin
            w6 = tbl[i].w;
            @(negedge clk);
            chk($sformatf("tbl%0d_z", i), 16'(z6), 16'(tbl[i].z));
            chk($sformatf("tbl%0d_y", i), 16'(y6), 16'(tbl[i].y));
        end

        // Mid-stream reset discards the sampled vector.
        w6  = 6'b010000;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_z", 16'(z6), 16'h0);
        chk("mid_rst_y", 16'(y6), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_z", 16'(z6), 16'h1);
        chk("mid_rel_y", 16'(y6), 16'h4);

        // Back-to-back sweep: exhaustive for n <= 8, mixed random upper bits for n = 16.
        prev = 16'h0;
        for (int i = 0; i < 256; i++) begin
            v = {8'($urandom_range(0, 255)), 8'(i)};
            drive_all(v);
            @(negedge clk);
            check_all(v);
            prev = v;
        end

        // Single-hot walk over all 16 bits of the widest instance.
        for (int k = 0; k < 16; k++) begin
            v = 16'h1 << k;
            drive_all(v);
            @(negedge clk);
            check_all(v);
        end

        drive_all(16'hFFFF);
        @(negedge clk);
        chk("final_ones_y16", 16'(y16), 16'd15);
        chk("final_ones_y5",  16'(y5),  16'd4);
        if (prev == 16'hFFFF) chk("prev_guard", 16'(z6), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
